fir_mac_sequencer: RTL

- Time-multiplexed controller for the team's FIR filter: one shared 8x8 multiplier and accumulator, sequenced over all taps, one MAC per clock.
- Holds a circular sample-history buffer and a run-time-programmable coefficient bank.
- Accepts samples on a valid/ready input and emits full-precision results on a valid/ready output.
- Sits between the sample source (ADC/stream) and downstream processing; replaces the fully parallel tap array where area matters.

---
 rtl/fir_mac_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiplier/accumulator walks every tap, one MAC per clock,
// over a circular sample history and a run-time-writable coefficient bank.
module fir_mac_sequencer #(
  parameter int taps        = 32,
  parameter int num_bits    = 8,
  parameter int input_size  = 8,
  parameter int output_size = 21
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [input_size-1:0]    Data_In,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [output_size-1:0]   Data_Out,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     coef_we,
  input  logic [$clog2(taps)-1:0]  coef_addr,
  input  logic [num_bits-1:0]      coef_data,
  output logic                     busy,
  output logic                     coef_err
);
  localparam int AW = $clog2(taps);
  localparam int PW = num_bits + input_size;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  state_t state, state_nxt;

  logic [input_size-1:0]  hist [taps];
  logic [num_bits-1:0]    coef [taps];
  logic [AW-1:0]          wp, idx, rd;
  logic [output_size-1:0] acc, acc_sum;
  logic [PW-1:0]          prod;
  logic                   accept, last;

  assign in_ready = reset && (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (idx == AW'(taps - 1));

  // AW-bit subtraction wraps, giving (wp - idx) mod taps for free.
  assign rd      = wp - idx;
  assign prod    = {{input_size{1'b0}}, coef[idx]} * {{num_bits{1'b0}}, hist[rd]};
  assign acc_sum = acc + {{(output_size - PW){1'b0}}, prod};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ACCUM;
      ACCUM:   if (last)      state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < taps; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
      wp        <= '0;
      idx       <= '0;
      acc       <= '0;
      Data_Out  <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
    end else begin
      // Writes land only between samples so a running MAC sweep sees a stable bank.
      if (coef_we && state != IDLE) coef_err <= 1'b1;
      case (state)
        IDLE: begin
          if (coef_we) coef[coef_addr] <= coef_data;
          if (accept) begin
            hist[wp] <= Data_In;
            acc      <= '0;
            idx      <= '0;
          end
        end
        ACCUM: begin
          acc <= acc_sum;
          idx <= idx + AW'(1);
          if (last) begin
            Data_Out  <= acc_sum;
            out_valid <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            wp        <= wp + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
